// File: rtl/dmem_lsu_arbiter.sv
// dmem_lsu_arbiter: load/store sequencer and two-port arbiter for a single-port,
// word-wide data memory. Converts byte/half/word loads and stores into word
// accesses, doing a read-modify-write for sub-word stores. One transaction is
// in flight at a time.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   c_req/c_we/c_funct3/c_addr/c_wdata, c_ack   core LSU request set and ack
//   d_req/d_we/d_funct3/d_addr/d_wdata, d_ack   debug/DMA request set and ack
//   rsp_rdata, rsp_err            load result and error flag, valid with ack
//   mem_WE, mem_addr, mem_WD      memory write enable, word address, write data
//   mem_RD                        memory read data (combinational from mem_addr)
//
// Build option: define DMEM_ARB_FIXED_PRIO_EN to give the core fixed priority on
// simultaneous requests; otherwise arbitration is round-robin.
module dmem_lsu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [2:0]       c_funct3,
  input  logic [DEPTH+1:0] c_addr,
  input  logic [WIDTH-1:0] c_wdata,
  output logic             c_ack,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [2:0]       d_funct3,
  input  logic [DEPTH+1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_ack,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             mem_WE,
  output logic [DEPTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_WD,
  input  logic [WIDTH-1:0] mem_RD
);

  typedef enum logic [1:0] {StIdle, StAccess, StWrite, StDone} state_e;

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;     // 0 = core, 1 = debug
  logic             last_q, last_d;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [DEPTH+1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] merge_q, merge_d;

  logic             take;
  logic             pick;
  logic             illegal;
  logic             is_sw;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] merged;

  // Arbitration: pick is the requester granted if a request is taken now.
  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    pick = !c_req;
`else
    pick = (c_req && d_req) ? !last_q : d_req;
`endif
  end

  // Legality of the latched request.
  always_comb begin
    case (f3_q)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = addr_q[0];
      3'b010:         illegal = (addr_q[1:0] != 2'b00);
      default:        illegal = 1'b1;
    endcase
    if (we_q && f3_q[2]) illegal = 1'b1;
  end

  assign is_sw = we_q && !illegal && (f3_q == 3'b010);

  // Load lane select and extension.
  always_comb begin
    shifted = mem_RD >> {addr_q[1:0], 3'b000};
    case (f3_q[1:0])
      2'b00:   load_val = f3_q[2] ? {{(WIDTH-8){1'b0}}, shifted[7:0]}
                                  : {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = f3_q[2] ? {{(WIDTH-16){1'b0}}, shifted[15:0]}
                                  : {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Sub-word store merge: replace the addressed byte/half, keep the other lanes.
  always_comb begin
    lane_mask = (f3_q[0] ? WIDTH'(16'hffff) : WIDTH'(8'hff)) << {addr_q[1:0], 3'b000};
    merged    = (merge_q & ~lane_mask) | ((wdata_q << {addr_q[1:0], 3'b000}) & lane_mask);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    merge_d = merge_q;
    take    = 1'b0;
    case (state_q)
      StIdle: begin
        if (c_req || d_req) begin
          take    = 1'b1;
          gnt_d   = pick;
          last_d  = pick;
          state_d = StAccess;
        end
      end
      StAccess: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = StDone;
        if (illegal) begin
          err_d = 1'b1;
        end else if (!we_q) begin
          rdata_d = load_val;
        end else if (!is_sw) begin
          merge_d = mem_RD;
          state_d = StWrite;
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;  // debug was "last", so the core wins first
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      merge_q <= merge_d;
      if (take) begin
        we_q    <= pick ? d_we     : c_we;
        f3_q    <= pick ? d_funct3 : c_funct3;
        addr_q  <= pick ? d_addr   : c_addr;
        wdata_q <= pick ? d_wdata  : c_wdata;
      end
    end
  end

  // Strobes are gated by reset_n so a reset cycle never writes or acks.
  assign mem_addr  = addr_q[DEPTH+1:2];
  assign mem_WE    = reset_n && (((state_q == StAccess) && is_sw) || (state_q == StWrite));
  assign mem_WD    = (state_q == StWrite) ? merged : wdata_q;
  assign c_ack     = reset_n && (state_q == StDone) && !gnt_q;
  assign d_ack     = reset_n && (state_q == StDone) && gnt_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/dmem_lsu_arbiter.md
Name: dmem_lsu_arbiter

Overview:
- Load/store sequencer and two-port arbiter in front of the single-port, word-wide data memory.
- Requesters: core LSU (c_*) and debug/DMA port (d_*).
- Converts RISC-V byte/half/word loads and stores into word accesses, with read-modify-write for sub-word stores.
- Round-robin arbitration, one transaction in flight.

Parameters:
- WIDTH, 32, data word width (fixed at 32 for byte-lane logic)
- DEPTH, 8, memory word-address width; byte address is DEPTH+2 bits

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- c_req  in  1  core request; held with operands stable until c_ack
- c_we  in  1  core store (1) / load (0)
- c_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads only for BU/HU)
- c_addr  in  DEPTH+2  core byte address
- c_wdata  in  WIDTH  core store data, right-aligned
- c_ack  out  1  one-cycle completion pulse to core
- d_req, d_we, d_funct3, d_addr, d_wdata  in  as c_*  debug port request set
- d_ack  out  1  one-cycle completion pulse to debug port
- rsp_rdata  out  WIDTH  load result, valid during the ack cycle
- rsp_err  out  1  misaligned/illegal flag, valid during the ack cycle
- mem_WE  out  1  memory write enable
- mem_addr  out  DEPTH  memory word address = latched addr[DEPTH+1:2]
- mem_WD  out  WIDTH  memory write data
- mem_RD  in  WIDTH  memory read data, combinational from mem_addr

Behaviour:
- Reset: synchronous, reset_n low at posedge → state IDLE, c_ack/d_ack/mem_WE/rsp_err 0, rsp_rdata 0, latched request 0, last_grant = debug (core wins first).
- States: IDLE, ACCESS, WRITE, DONE.
- IDLE: on a posedge with any req, latch winner's we/funct3/addr/wdata and grant id → ACCESS. If both requesters are active, the requester not in last_grant wins; update last_grant.
- ACCESS: mem_addr driven from the latched address.
  - Illegal case (H with addr[0]=1, W with addr[1:0]≠0, funct3 011/110/111, or store with funct3 bit2 set): set err → DONE, mem_WE 0.
  - Load: capture mem_RD, select lane by addr[1:0], sign- or zero-extend → DONE.
  - SW: mem_WE=1 and mem_WD=wdata this cycle → DONE.
  - SB/SH: capture mem_RD into merge register → WRITE.
- WRITE: mem_WE=1, mem_WD = merged word (byte/half replaced in lane addr[1:0]; other lanes unchanged) → DONE.
- DONE: pulse the granted requester's ack. rsp_rdata holds the load result (0 for stores and errors); rsp_err holds the error flag → IDLE.
- Latency from req sampled in IDLE:
  - loads, SW and errors: ack 2 cycles later
  - SB/SH: ack 3 cycles later
- Throughput: a new request is accepted on the first IDLE cycle after DONE. A requester must drop req the cycle after ack, or it is treated as a new request.
- mem_WE is asserted only in ACCESS (SW) or WRITE, at most one cycle per transaction.
- Reset mid-transaction: abort with no write, no ack.
- A req deasserted before ack is a protocol violation; the transaction completes anyway.

Optional Feature:
- DMEM_ARB_FIXED_PRIO_EN defined: core always wins simultaneous requests and last_grant is ignored.
- Undefined: round-robin as above.

Test Plan:
- Core SW 0x10, data 0xDEADBEEF → mem_WE high one cycle at mem_addr 4, c_ack 2 cycles after req. Then LW 0x10 → rsp_rdata 0xDEADBEEF, rsp_err 0.
- Core SB 0x11, data 0x000000AA → mem_WE only in WRITE with mem_WD 0xDEADAAEF, ack at +3. Then LB 0x11 → 0xFFFFFFAA; LBU 0x11 → 0x000000AA; LHU 0x12 → 0x0000DEAD.
- c_req and d_req held together from reset, each dropped 1 cycle after its ack then re-raised → grants alternate core, debug, core, debug; d_ack never coincides with c_ack.
- LW 0x12, SH 0x13, funct3 011 → ack at +2 with rsp_err 1, rsp_rdata 0, mem_WE never asserted, memory unchanged.
- SH 0x10 with reset_n low in the WRITE cycle → no mem_WE, no ack, all outputs 0 next cycle, word unchanged.
- DMEM_ARB_FIXED_PRIO_EN defined, both requesting continuously → core granted every transaction, d_ack never asserted.
